// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, exception codes and instruction formats
// shared by the decode stage and its immediate generator.
package decode_pkg;

    localparam int EX_W = 4;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam logic [EX_W-1:0] EX_ILLEGAL_INSTR = 4'd2;
    localparam logic [EX_W-1:0] EX_BREAKPOINT    = 4'd3;
    localparam logic [EX_W-1:0] EX_ECALL_M       = 4'd11;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_X
    } fmt_e;

    // FMT_X marks an opcode outside RV32I (also catches instr[1:0] != 2'b11)
    function automatic fmt_e fmt_of(input logic [6:0] op);
        fmt_e f;
        case (op)
            OP_LUI, OP_AUIPC:  f = FMT_U;
            OP_JAL:            f = FMT_J;
            OP_BRANCH:         f = FMT_B;
            OP_STORE:          f = FMT_S;
            OP_OP:             f = FMT_R;
            OP_JALR, OP_LOAD, OP_IMM,
            OP_MISC_MEM, OP_SYSTEM: f = FMT_I;
            default:           f = FMT_X;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// decode_stage_imm_gen: instruction format classification and
// sign-extended RV32I immediate generation.
module decode_stage_imm_gen
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm,
    output fmt_e        fmt
);

    logic s;

    assign s   = instr[31];
    assign fmt = fmt_of(instr[6:0]);

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I: imm = {{20{s}}, instr[31:20]};
            FMT_S: imm = {{20{s}}, instr[31:25], instr[11:7]};
            FMT_B: imm = {{19{s}}, s, instr[7], instr[30:25],
                          instr[11:8], 1'b0};
            FMT_U: imm = {instr[31:12], 12'b0};
            FMT_J: imm = {{11{s}}, s, instr[19:12], instr[20],
                          instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode, register read with writeback bypass,
// load-use hazard detection and registered decode packet.
module decode_stage
    import decode_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   instr_in,
    input  logic [XLEN-1:0]   pc_in,
    input  logic [EX_W-1:0]   ex_in,
    input  logic              ex_valid_in,
    input  logic              valid_in,
    input  logic              stall_in,
    input  logic              flush,
    output logic              stall_out,
    output logic [REG_AW-1:0] rs1_addr,
    output logic [REG_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   pc_out,
    output logic [6:0]        opcode_out,
    output logic [2:0]        funct3_out,
    output logic              funct7b5_out,
    output logic [REG_AW-1:0] rd_out,
    output logic [XLEN-1:0]   op1_out,
    output logic [XLEN-1:0]   op2_out,
    output logic [XLEN-1:0]   imm_out,
    output logic [EX_W-1:0]   exception,
    output logic              exception_valid,
    output logic              pipeline_valid
);

    logic [XLEN-1:0]   imm;
    fmt_e              fmt;
    logic              use_rs1;
    logic              use_rs2;
    logic              hazard;
    logic [EX_W-1:0]   ex_nxt;
    logic              exv_nxt;
    logic [REG_AW-1:0] rd_nxt;

    decode_stage_imm_gen u_imm_gen (
        .instr (instr_in),
        .imm   (imm),
        .fmt   (fmt)
    );

    assign rs1_addr = instr_in[19:15];
    assign rs2_addr = instr_in[24:20];

    assign use_rs1 = !(fmt inside {FMT_U, FMT_J});
    assign use_rs2 = fmt inside {FMT_R, FMT_S, FMT_B};

    // load in the packet register feeding the instruction now at fetch
    assign hazard = pipeline_valid && (opcode_out == OP_LOAD)
                 && (rd_out != '0) && valid_in
                 && ((use_rs1 && rd_out == rs1_addr)
                  || (use_rs2 && rd_out == rs2_addr));

    assign stall_out = !flush && (stall_in || hazard);

    always_comb begin
        ex_nxt  = '0;
        exv_nxt = 1'b1;
        priority case (1'b1)
            ex_valid_in:              ex_nxt  = ex_in;
            fmt == FMT_X:             ex_nxt  = EX_ILLEGAL_INSTR;
            instr_in == INSTR_ECALL:  ex_nxt  = EX_ECALL_M;
            instr_in == INSTR_EBREAK: ex_nxt  = EX_BREAKPOINT;
            default:                  exv_nxt = 1'b0;
        endcase
    end

    assign rd_nxt = (exv_nxt || fmt inside {FMT_S, FMT_B})
                  ? '0 : instr_in[11:7];

    function automatic logic [XLEN-1:0] bypass(
        input logic [REG_AW-1:0] a,
        input logic [XLEN-1:0]   d
    );
        if (a == '0)
            return '0;
        if (wb_en && wb_rd == a)
            return wb_data;
        return d;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            pipeline_valid  <= 1'b0;
            exception_valid <= 1'b0;
            exception       <= '0;
            pc_out          <= '0;
            opcode_out      <= '0;
            funct3_out      <= '0;
            funct7b5_out    <= 1'b0;
            rd_out          <= '0;
            op1_out         <= '0;
            op2_out         <= '0;
            imm_out         <= '0;
        end else if (flush) begin
            pipeline_valid  <= 1'b0;
            exception_valid <= 1'b0;
        end else if (!stall_in) begin
            if (hazard || !valid_in) begin
                pipeline_valid  <= 1'b0;
                exception_valid <= 1'b0;
            end else begin
                pipeline_valid  <= 1'b1;
                exception_valid <= exv_nxt;
                exception       <= ex_nxt;
                pc_out          <= pc_in;
                opcode_out      <= instr_in[6:0];
                funct3_out      <= instr_in[14:12];
                funct7b5_out    <= instr_in[30];
                rd_out          <= rd_nxt;
                op1_out         <= bypass(rs1_addr, rs1_data);
                op2_out         <= bypass(rs2_addr, rs2_data);
                imm_out         <= imm;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random stimulus for decode_stage,
// checked against a cycle-level reference model of the stage.
module tb_decode_stage;

    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F;
    localparam logic [6:0] JALR = 7'h67, BR = 7'h63, LD = 7'h03;
    localparam logic [6:0] ST = 7'h23, OPI = 7'h13, OPR = 7'h33;
    localparam logic [6:0] FENCE = 7'h0F, SYS = 7'h73;
    localparam logic [6:0] KNOWN [11] = '{LUI, AUIPC, JAL, JALR, BR,
        LD, ST, OPI, OPR, FENCE, SYS};

    logic        clk = 1'b0;
    logic        reset, valid_in, stall_in, flush, ex_valid_in, wb_en;
    logic [31:0] instr_in, pc_in, wb_data;
    logic [3:0]  ex_in;
    logic [4:0]  wb_rd;
    logic        stall_out, funct7b5_out, exception_valid, pipeline_valid;
    logic [4:0]  rs1_addr, rs2_addr, rd_out;
    logic [31:0] rs1_data, rs2_data, pc_out, op1_out, op2_out, imm_out;
    logic [6:0]  opcode_out;
    logic [2:0]  funct3_out;
    logic [3:0]  exception;

    logic [31:0] regs [32];

    assign rs1_data = regs[instr_in[19:15]];
    assign rs2_data = regs[instr_in[24:20]];

    always #5 clk = ~clk;

    decode_stage dut (
        .clk (clk), .reset (reset),
        .instr_in (instr_in), .pc_in (pc_in),
        .ex_in (ex_in), .ex_valid_in (ex_valid_in),
        .valid_in (valid_in), .stall_in (stall_in), .flush (flush),
        .stall_out (stall_out),
        .rs1_addr (rs1_addr), .rs2_addr (rs2_addr),
        .rs1_data (rs1_data), .rs2_data (rs2_data),
        .wb_en (wb_en), .wb_rd (wb_rd), .wb_data (wb_data),
        .pc_out (pc_out), .opcode_out (opcode_out),
        .funct3_out (funct3_out), .funct7b5_out (funct7b5_out),
        .rd_out (rd_out), .op1_out (op1_out), .op2_out (op2_out),
        .imm_out (imm_out), .exception (exception),
        .exception_valid (exception_valid),
        .pipeline_valid (pipeline_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h @%0t", tag, got, exp,
                     $time);
        end
    endtask

    // reference model state: what the packet register should hold
    bit          m_pv, m_exv, m_immk, last_stall;
    logic [31:0] m_pc, m_op1, m_op2, m_imm;
    logic [6:0]  m_opc;
    logic [2:0]  m_f3;
    logic        m_f7;
    logic [4:0]  m_rd;
    logic [3:0]  m_exc;

    function automatic bit known(input logic [6:0] o);
        foreach (KNOWN[k])
            if (KNOWN[k] == o)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        int v;
        case (i[6:0])
            LUI, AUIPC: return i & 32'hFFFF_F000;
            OPR:        return 32'h0;
            JAL: v = int'(i[19:12]) * 4096 + int'(i[20]) * 2048
                   + int'(i[30:21]) * 2 - (i[31] ? (1 << 20) : 0);
            BR:  v = int'(i[7]) * 2048 + int'(i[30:25]) * 32
                   + int'(i[11:8]) * 2 - (i[31] ? 4096 : 0);
            ST:  v = int'(i[30:25]) * 32 + int'(i[11:7])
                   - (i[31] ? 2048 : 0);
            default: v = int'(i[30:20]) - (i[31] ? 2048 : 0);
        endcase
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a,
        input logic we, input logic [4:0] wrd, input logic [31:0] wd);
        if (a == 0)
            return 32'h0;
        return (we && wrd == a) ? wd : regs[a];
    endfunction

    // one clock: drive at negedge, check combinational outputs,
    // advance the model, check registered outputs at the next negedge
    task automatic step(input logic rst, input logic fl, input logic st,
                        input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input logic exv,
                        input logic [3:0] exc, input logic we,
                        input logic [4:0] wrd, input logic [31:0] wd);
        bit u1, u2, hz, xv;
        logic [3:0] xc;
        reset = rst; flush = fl; stall_in = st; valid_in = v;
        instr_in = ins; pc_in = pc; ex_valid_in = exv; ex_in = exc;
        wb_en = we; wb_rd = wrd; wb_data = wd;
        #1;
        u1 = !(ins[6:0] inside {LUI, AUIPC, JAL});
        u2 = ins[6:0] inside {OPR, ST, BR};
        hz = m_pv && m_opc == LD && m_rd != 0 && v
          && ((u1 && m_rd == ins[19:15]) || (u2 && m_rd == ins[24:20]));
        last_stall = !fl && (st || hz);
        check("rs1_addr", rs1_addr, ins[19:15]);
        check("rs2_addr", rs2_addr, ins[24:20]);
        check("stall_out", stall_out, last_stall);
        if (rst) begin
            m_pv = 0; m_exv = 0; m_exc = 0; m_pc = 0; m_opc = 0;
            m_f3 = 0; m_f7 = 0; m_rd = 0; m_op1 = 0; m_op2 = 0;
            m_imm = 0; m_immk = 1;
        end else if (fl) begin
            m_pv = 0; m_exv = 0;
        end else if (!st) begin
            if (hz || !v) begin
                m_pv = 0; m_exv = 0;
            end else begin
                xv = 1; xc = 0;
                if (exv) xc = exc;
                else if (!known(ins[6:0])) xc = 2;
                else if (ins == 32'h73) xc = 11;
                else if (ins == 32'h0010_0073) xc = 3;
                else xv = 0;
                m_pv = 1; m_exv = xv; m_exc = xc; m_pc = pc;
                m_opc = ins[6:0]; m_f3 = ins[14:12]; m_f7 = ins[30];
                m_rd = (xv || ins[6:0] inside {ST, BR}) ? 5'd0 : ins[11:7];
                m_op1 = ref_read(ins[19:15], we, wrd, wd);
                m_op2 = ref_read(ins[24:20], we, wrd, wd);
                m_immk = known(ins[6:0]);
                m_imm = ref_imm(ins);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("pipeline_valid", pipeline_valid, m_pv);
        check("exception_valid", exception_valid, m_exv);
        if (m_exv || rst) check("exception", exception, m_exc);
        if (m_pv || rst) begin
            check("pc_out", pc_out, m_pc);
            check("opcode_out", opcode_out, m_opc);
            check("funct3_out", funct3_out, m_f3);
            check("funct7b5_out", funct7b5_out, m_f7);
            check("rd_out", rd_out, m_rd);
            check("op1_out", op1_out, m_op1);
            check("op2_out", op2_out, m_op2);
            if (m_immk) check("imm_out", imm_out, m_imm);
        end
    endtask

    task automatic go(input logic [31:0] ins, input logic [31:0] pc);
        step(0, 0, 0, 1, ins, pc, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] ins, pc;
        logic [6:0]  opc;
        int sel;
        foreach (regs[k]) regs[k] = $urandom;
        regs[0] = 32'h5A5A_0001;
        reset = 1; flush = 0; stall_in = 0; valid_in = 0;
        instr_in = 0; pc_in = 0; ex_valid_in = 0; ex_in = 0;
        wb_en = 0; wb_rd = 0; wb_data = 0;
        @(negedge clk);

        step(1, 0, 0, 1, 32'h0050_0093, 32'h10, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 32'h0050_0093, 32'h10, 0, 0, 0, 0, 0);

        go(32'h0050_0093, 32'h10);
        check("addi_imm", imm_out, 32'd5);
        check("addi_rd", rd_out, 32'd1);
        check("addi_op1", op1_out, 32'd0);

        go(32'h0000_A103, 32'h14);
        go(32'h0011_01B3, 32'h18);
        check("loaduse_bubble", pipeline_valid, 32'd0);
        go(32'h0011_01B3, 32'h18);
        check("loaduse_add_rd", rd_out, 32'd3);

        go(32'hFFFF_FFFF, 32'h1C);
        check("illegal_code", exception, 32'd2);
        go(32'h0000_0073, 32'h20);
        check("ecall_code", exception, 32'd11);
        go(32'h0010_0073, 32'h24);
        step(0, 0, 0, 1, 32'h0000_0013, 32'h28, 1, 4'd7, 0, 0, 0);

        go(32'hFE00_0CE3, 32'h2C);
        check("beq_imm", imm_out, 32'hFFFF_FFF8);
        regs[1] = 32'h0;
        step(0, 0, 0, 1, 32'h0000_8293, 32'h30, 0, 0, 1, 5'd1,
             32'hDEAD_BEEF);
        check("bypass_op1", op1_out, 32'hDEAD_BEEF);
        regs[1] = $urandom;

        go(32'h0000_A103, 32'h34);
        for (int k = 0; k < 3; k++)
            step(0, 0, 1, 1, 32'h0011_01B3, 32'h38, 0, 0, 0, 0, 0);
        check("stall_hold_pc", pc_out, 32'h34);
        step(0, 1, 0, 1, 32'h0011_01B3, 32'h38, 0, 0, 0, 0, 0);
        check("flush_pv", pipeline_valid, 32'd0);

        pc = 32'h100;
        ins = 32'h13;
        for (int c = 0; c < 500; c++) begin
            if (!last_stall) begin
                sel = $urandom_range(0, 19);
                opc = KNOWN[$urandom_range(0, 10)];
                if (sel < 5) opc = LD;
                if (sel == 17) opc = 7'($urandom);
                ins = $urandom;
                ins[6:0] = opc;
                ins[11:7] = 5'($urandom_range(0, 3));
                ins[19:15] = 5'($urandom_range(0, 3));
                ins[24:20] = 5'($urandom_range(0, 3));
                if (sel == 18) ins = 32'h0000_0073;
                if (sel == 19) ins = 32'h0010_0073;
                pc = pc + 4;
            end
            step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 7) != 0,
                 ins, pc, $urandom_range(0, 19) == 0, 4'($urandom),
                 1'($urandom), 5'($urandom_range(0, 3)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Second pipeline stage, directly downstream of fetch. Accepts the fetched instruction, PC and exception status. Decodes RV32I fields and immediates, reads the register file, and presents a registered decode packet to execute. Back-pressures fetch via stall_out on downstream stall or a load-use hazard; flush clears it.

Parameters:
REG_AW, 5, register address width.
XLEN, 32, data/immediate width; equals `INSTR_SIZE+1 and `ADDR_SIZE+1 in def_params.v.

Ports:
clk  in  1  clock, all state updates on posedge.
reset  in  1  synchronous, active-high reset.
instr_in  in  `INSTR_SIZE+1  instruction from fetch.
pc_in  in  `ADDR_SIZE+1  PC of instr_in.
ex_in  in  `EX_WIDTH+1  fetch exception code.
ex_valid_in  in  1  fetch exception valid.
valid_in  in  1  fetch pipeline_valid.
stall_in  in  1  downstream stall.
flush  in  1  pipeline flush.
stall_out  out  1  to fetch stall input.
rs1_addr, rs2_addr  out  REG_AW  combinational regfile read addresses.
rs1_data, rs2_data  in  XLEN  combinational regfile read data.
wb_en  in  1  writeback enable (bypass).
wb_rd  in  REG_AW  writeback destination.
wb_data  in  XLEN  writeback data.
pc_out  out  `ADDR_SIZE+1  registered PC.
opcode_out  out  7  instr[6:0].
funct3_out  out  3  instr[14:12].
funct7b5_out  out  1  instr[30].
rd_out  out  REG_AW  destination; 0 when the format has no rd.
op1_out, op2_out  out  XLEN  bypassed rs1/rs2 values.
imm_out  out  XLEN  sign-extended immediate.
exception  out  `EX_WIDTH+1  exception code.
exception_valid  out  1  exception present.
pipeline_valid  out  1  decode packet valid.

Behaviour:
- Reset: pipeline_valid=0, exception_valid=0, exception=0. pc_out, opcode_out, funct3_out, funct7b5_out, rd_out, op1_out, op2_out and imm_out are all 0.
- rs1_addr=instr_in[19:15] and rs2_addr=instr_in[24:20], always combinational.
- Hazard (combinational): pipeline_valid && opcode_out==LOAD(0000011) && rd_out!=0 && valid_in && ((rs1 used && rd_out==rs1_addr) || (rs2 used && rd_out==rs2_addr)).
  - rs1 is used by all formats except LUI, AUIPC and JAL.
  - rs2 is used by R, S and B formats only.
- stall_out = stall_in || hazard, combinational. When flush=1, stall_out=0.
- Priority at posedge: reset > flush > stall_in > hazard > accept.
  - flush: pipeline_valid<=0, exception_valid<=0; other outputs don't-care.
  - stall_in: all output registers hold.
  - hazard: pipeline_valid<=0 (bubble). Input is not consumed; fetch holds it. The hazard clears the next cycle because pipeline_valid is then 0.
  - accept (valid_in=1): latch all fields, pipeline_valid<=1. Latency is 1 cycle.
  - no valid_in: pipeline_valid<=0.
- Immediates: I, S, B, U and J formats per the RV32I spec, sign-extended from instr[31]. B and J immediates have bit0=0. R format gives imm=0.
- Bypass: if wb_en && wb_rd!=0 && wb_rd==rs1_addr, then op1<=wb_data, else op1<=rs1_data. op2 follows the same rule. x0 always reads 0 regardless of rs*_data.
- Exceptions, first match wins:
  1. ex_valid_in: pass ex_in through.
  2. Unknown opcode, or instr[1:0]!=11: `EX_ILLEGAL_INSTR.
  3. Exactly 0x00000073: `EX_ECALL_M.
  4. Exactly 0x00100073: `EX_BREAKPOINT.
  5. Otherwise exception_valid<=0.
- An excepting instruction still sets pipeline_valid=1. rd_out is forced to 0 for excepting instructions.
- Known opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM.
- Simultaneous flush and hazard: flush wins, stall_out=0.

Decomposition:
- def_params.v gains:
  - opcode constants `OP_LUI … `OP_SYSTEM.
  - `EX_ILLEGAL_INSTR (2), `EX_BREAKPOINT (3), `EX_ECALL_M (11).
  - `REG_ADDR_SIZE (4).
- One natural sub-module: imm_gen, a combinational instr→imm/format-select block.

Test Plan:
1. Reset with valid_in=1, instr 0x00500093 → pipeline_valid=0, exception_valid=0, stall_out=0 during reset.
2. addi x1,x0,5 (0x00500093), pc 0x10 → next cycle: pipeline_valid=1, rd_out=1, imm_out=5, op1_out=0, pc_out=0x10, exception_valid=0.
3. lw x2,0(x1) accepted, then add x3,x2,x1 presented → stall_out=1 for one cycle and pipeline_valid=0 bubble; the following cycle add is accepted with rd_out=3.
4. instr 0xFFFFFFFF → exception_valid=1, exception=2, rd_out=0. instr 0x00000073 → exception=11.
5. beq with imm -8 (0xFE000CE3) → imm_out=0xFFFFFFF8. Bypass case: wb_en=1, wb_rd=1, wb_data=0xDEADBEEF while rs1_data=0 → op1_out=0xDEADBEEF.
6. stall_in=1 for 3 cycles → all outputs held, stall_out=1. Then flush=1 concurrently with hazard → pipeline_valid=0, stall_out=0.
